// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack and its burst sequencing controller.
// Holds op codes, the controller state encoding and the length-width helper.
// No logic; imported by stack and stack_seq_ctrl.
package stack_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PUSH_FETCH = 3'd1;
    localparam logic [2:0] ST_POP_CHECK  = 3'd2;
    localparam logic [2:0] ST_ISSUE      = 3'd3;
    localparam logic [2:0] ST_SETTLE     = 3'd4;
    localparam logic [2:0] ST_DELIVER    = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        PUSH_FETCH = ST_PUSH_FETCH,
        POP_CHECK  = ST_POP_CHECK,
        ISSUE      = ST_ISSUE,
        SETTLE     = ST_SETTLE,
        DELIVER    = ST_DELIVER,
        DONE       = ST_DONE
    } state_t;

    // Width able to hold any count 0..depth inclusive.
    function automatic int len_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stack.sv
// LIFO stack: push/pop sampled on the rising edge, data_out registered on pop.
// Latency: data_out/full/empty reflect an operation on the edge after its strobe.
// Backpressure: push when full and pop when empty are ignored; push wins if both.
// Ports: clk, rstn; push, pop, data_in in; data_out, full, empty out.
module stack
    import stack_pkg::*;
#(
    parameter int BANDWIDTH = 4,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic                 pop,
    input  logic [BANDWIDTH-1:0] data_in,
    output logic [BANDWIDTH-1:0] data_out,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = len_width(DEPTH);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BANDWIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     sp;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (sp == PTR_W'(DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[AW'(sp)] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp       <= '0;
            data_out <= '0;
        end else if (do_push) begin
            sp <= sp + PTR_W'(1);
        end else if (do_pop) begin
            sp       <= sp - PTR_W'(1);
            data_out <= mem[AW'(sp - PTR_W'(1))];
        end
    end

endmodule

// File: rtl/stack_seq_ctrl.sv
// Burst initiator for one LIFO stack: runs "push N" / "pop N" commands word by word.
// Latency: first stack strobe 2 cycles after command accept; push 3 cycles/word, pop 4 cycles/word.
// Backpressure: waits on wr_valid and rd_ready; ends a burst early with err on full/empty.
// Ports: cmd_* command in; wr_* source in; rd_* sink out; stk_* to/from the stack;
//        done pulse with done_count/err status held until the next done.
module stack_seq_ctrl
    import stack_pkg::*;
#(
    parameter int BANDWIDTH = 4,
    parameter int DEPTH     = 8,
    parameter int LEN_W     = len_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [BANDWIDTH-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [BANDWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [BANDWIDTH-1:0] stk_data_in,
    input  logic [BANDWIDTH-1:0] stk_data_out,
    input  logic                 stk_full,
    input  logic                 stk_empty,
    output logic                 done,
    output logic [LEN_W-1:0]     done_count,
    output logic                 err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);

    state_t               state;
    state_t               state_nx;
    logic                 op;
    logic                 op_nx;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     len_nx;
    logic [LEN_W-1:0]     cnt;
    logic [LEN_W-1:0]     cnt_nx;
    logic                 err_flag;
    logic                 err_flag_nx;
    logic [BANDWIDTH-1:0] data_in_nx;
    logic [BANDWIDTH-1:0] rd_data_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        op_nx       = op;
        len_nx      = len;
        cnt_nx      = cnt;
        err_flag_nx = err_flag;
        data_in_nx  = stk_data_in;
        rd_data_nx  = rd_data;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_nx       = cmd_op;
                    len_nx      = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    cnt_nx      = '0;
                    err_flag_nx = 1'b0;
                    if (cmd_len == '0) begin
                        state_nx = DONE;
                    end else if (cmd_op == OP_PUSH) begin
                        state_nx = PUSH_FETCH;
                    end else begin
                        state_nx = POP_CHECK;
                    end
                end
            end
            PUSH_FETCH: begin
                // Full is checked before taking a word so no source data is lost.
                if (stk_full) begin
                    err_flag_nx = 1'b1;
                    state_nx    = DONE;
                end else if (wr_valid) begin
                    wr_ready   = 1'b1;
                    data_in_nx = wr_data;
                    state_nx   = ISSUE;
                end
            end
            POP_CHECK: begin
                if (stk_empty) begin
                    err_flag_nx = 1'b1;
                    state_nx    = DONE;
                end else begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = SETTLE;
            end
            SETTLE: begin
                // The stack has updated data_out/full/empty by the end of this cycle.
                if (op == OP_PUSH) begin
                    cnt_nx   = cnt + LEN_W'(1);
                    state_nx = (cnt_nx == len) ? DONE : PUSH_FETCH;
                end else begin
                    rd_data_nx = stk_data_out;
                    state_nx   = DELIVER;
                end
            end
            DELIVER: begin
                if (rd_ready) begin
                    cnt_nx   = cnt + LEN_W'(1);
                    state_nx = (cnt_nx == len) ? DONE : POP_CHECK;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Registered outputs are loaded from the next state so each one is
    // aligned with the state it belongs to (strobes in ISSUE, rd_valid in
    // DELIVER, done in DONE).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op          <= OP_PUSH;
            len         <= '0;
            cnt         <= '0;
            err_flag    <= 1'b0;
            stk_data_in <= '0;
            rd_data     <= '0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            done_count  <= '0;
            err         <= 1'b0;
        end else begin
            op          <= op_nx;
            len         <= len_nx;
            cnt         <= cnt_nx;
            err_flag    <= err_flag_nx;
            stk_data_in <= data_in_nx;
            rd_data     <= rd_data_nx;
            stk_push    <= (state_nx == ISSUE) && (op_nx == OP_PUSH);
            stk_pop     <= (state_nx == ISSUE) && (op_nx == OP_POP);
            rd_valid    <= (state_nx == DELIVER);
            done        <= (state_nx == DONE);
            if (state_nx == DONE) begin
                done_count <= cnt_nx;
                err        <= err_flag_nx;
            end
        end
    end

endmodule
